// File: rtl/lsu_defs.sv
// ============================================================================
// lsu_defs : access-size and FSM-state encodings shared by the LSU files
// Rev 1.0
// ============================================================================
`default_nettype none

package lsu_defs;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_WR   = 2'b10,
        S_DONE = 2'b11
    } lsu_state_e;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// lsu_align : load lane extract/extend, store lane merge, misalignment check
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_defs::*;
(
    input  logic [31:0] ld_word_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  chk_size_i,
    input  logic [1:0]  chk_offset_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o,
    output logic        misaligned_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = ld_word_i[{offset_i, 3'b000} +: 8];
    assign w_half = ld_word_i[{offset_i[1], 4'b0000} +: 16];

    always_comb begin
        ld_data_o = ld_word_i;
        case (size_i)
            SIZE_BYTE: ld_data_o = {{24{~unsigned_i & w_byte[7]}}, w_byte};
            SIZE_HALF: ld_data_o = {{16{~unsigned_i & w_half[15]}}, w_half};
            default:   ld_data_o = ld_word_i;
        endcase
    end

    // Sub-word stores overwrite only the addressed lane of the old word.
    always_comb begin
        st_word_o = ld_word_i;
        case (size_i)
            SIZE_BYTE: st_word_o[{offset_i, 3'b000} +: 8]     = wdata_i[7:0];
            SIZE_HALF: st_word_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default:   st_word_o = wdata_i;
        endcase
    end

    always_comb begin
        misaligned_o = 1'b1;
        case (chk_size_i)
            SIZE_BYTE: misaligned_o = 1'b0;
            SIZE_HALF: misaligned_o = chk_offset_i[0];
            SIZE_WORD: misaligned_o = |chk_offset_i;
            default:   misaligned_o = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : sequential byte/half/word LSU with read-modify-write stores
// Rev 1.0
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_defs::*;
#(
    parameter int ADDR_SIZE = 5,
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [1:0]           size_i,
    input  logic                 unsigned_i,
    input  logic [31:0]          addr_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    output logic                 ready_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [WORD_SIZE-1:0] rdata_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [WORD_SIZE-1:0] mem_data_o,
    output logic                 mem_wen_o,
    input  logic [WORD_SIZE-1:0] mem_data_i
);

    lsu_state_e           r_state;
    lsu_state_e           w_state_nxt;
    logic                 r_we;
    logic [1:0]           r_size;
    logic                 r_uns;
    logic [1:0]           r_off;
    logic [WORD_SIZE-1:0] r_wdata;
    logic [ADDR_SIZE-1:0] r_waddr;
    logic                 r_err;
    logic [WORD_SIZE-1:0] r_rdata;
    logic [WORD_SIZE-1:0] r_mem_data;

    logic                 w_accept;
    logic                 w_misaligned;
    logic [WORD_SIZE-1:0] w_ld_data;
    logic [WORD_SIZE-1:0] w_st_word;
    logic                 w_unused_addr;

    // Upper byte-address bits are dropped so accesses wrap within the memory.
    assign w_unused_addr = ^addr_i[31:ADDR_SIZE+2];

    lsu_align u_align (
        .ld_word_i    (mem_data_i),
        .size_i       (r_size),
        .offset_i     (r_off),
        .unsigned_i   (r_uns),
        .wdata_i      (r_wdata),
        .chk_size_i   (size_i),
        .chk_offset_i (addr_i[1:0]),
        .ld_data_o    (w_ld_data),
        .st_word_o    (w_st_word),
        .misaligned_o (w_misaligned)
    );

    assign w_accept = req_i && (r_state == S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    if (w_misaligned)
                        w_state_nxt = S_DONE;
                    else if (we_i && (size_i == SIZE_WORD))
                        w_state_nxt = S_WR;
                    else
                        w_state_nxt = S_RD;
                end
            end
            S_RD:    w_state_nxt = r_we ? S_WR : S_DONE;
            S_WR:    w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_size     <= SIZE_BYTE;
            r_uns      <= 1'b0;
            r_off      <= 2'b00;
            r_wdata    <= '0;
            r_waddr    <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_mem_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we    <= we_i;
                r_size  <= size_i;
                r_uns   <= unsigned_i;
                r_off   <= addr_i[1:0];
                r_wdata <= wdata_i;
                r_waddr <= addr_i[ADDR_SIZE+1:2];
                r_err   <= w_misaligned;
                // Word stores skip the read, so their write data is known now.
                if (we_i && (size_i == SIZE_WORD))
                    r_mem_data <= wdata_i;
            end
            if (r_state == S_RD) begin
                if (r_we)
                    r_mem_data <= w_st_word;
                else
                    r_rdata <= w_ld_data;
            end
        end
    end

    assign ready_o    = (r_state == S_IDLE);
    assign done_o     = (r_state == S_DONE);
    assign err_o      = r_err && (r_state == S_DONE);
    assign rdata_o    = r_rdata;
    assign mem_addr_o = r_waddr;
    assign mem_data_o = r_mem_data;
    assign mem_wen_o  = (r_state == S_WR);

endmodule

`default_nettype wire
